// File: rtl/v_display_diff_tx.sv
// ---------------------------------------------------------------------------
// v_display_diff_tx
//   Virtual-display diff transmitter. Keeps a shadow copy of the last image
//   sent to the host. It scans a snapshot of the live display buffer one byte
//   per cycle, and emits every changed byte as a {data, index} chunk over a
//   valid/ack handshake. A refresh request forces the next scan to send every
//   byte. Each byte is committed to the shadow only once it has been acked, so
//   display edits made during a scan are picked up by the following scan.
//
// Ports
//   CLK, RST        clock / synchronous active-high reset
//   display         live display buffer, byte i = display[i*8 +: 8]
//   refresh         one-cycle request to resend the whole image
//   should_update   chunk valid (FSM in SEND)
//   tx_chunk_type   constant chunk type
//   tx_chunk_bytes  {data byte, zero-extended index}
//   tx_ack          consumer accepted the current chunk
//   busy            scan in progress (FSM not IDLE)
//   scan_done       one-cycle pulse at the end of each scan
//   chunks_sent     number of chunks acked in the last completed scan
// ---------------------------------------------------------------------------
module v_display_diff_tx #(
    parameter logic [7:0] INTERFACE_TX_CHUNK_TYPE   = 8'd6,
    parameter int         DISPLAY_BUFFER_BYTE_SIZE  = 64,
    parameter int         DISPLAY_BUFFER_INDEX_SIZE = 8,
    parameter int         INDEX_BYTES               = 1
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [DISPLAY_BUFFER_BYTE_SIZE*8-1:0]   display,
    input  logic                                    refresh,
    output logic                                    should_update,
    output logic [7:0]                              tx_chunk_type,
    output logic [8*(INDEX_BYTES+1)-1:0]            tx_chunk_bytes,
    input  logic                                    tx_ack,
    output logic                                    busy,
    output logic                                    scan_done,
    output logic [DISPLAY_BUFFER_INDEX_SIZE:0]      chunks_sent
);

    localparam int N   = DISPLAY_BUFFER_BYTE_SIZE;
    localparam int IW  = DISPLAY_BUFFER_INDEX_SIZE;
    localparam int IXW = 8 * INDEX_BYTES;
    localparam int CW  = 8 * (INDEX_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [N*8-1:0]    r_shadow;
    logic [N*8-1:0]    r_snap;
    logic [IW-1:0]     r_idx;
    logic              r_full;
    logic              r_refresh_pending;
    logic [CW-1:0]     r_chunk;
    logic [IW:0]       r_cnt;
    logic [IW:0]       r_chunks_sent;

    logic [7:0]        w_snap_byte;
    logic [7:0]        w_shadow_byte;
    logic              w_last;
    logic              w_start;
    logic              w_load;
    logic              w_commit;
    logic              w_adv;
    logic              w_finish;

    // Byte selection by constant-index compare keeps the select width exact
    // regardless of how IW relates to log2(N).
    always_comb begin
        w_snap_byte   = '0;
        w_shadow_byte = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) begin
                w_snap_byte   = r_snap[i*8 +: 8];
                w_shadow_byte = r_shadow[i*8 +: 8];
            end
        end
    end

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_load        = 1'b0;
        w_commit      = 1'b0;
        w_adv         = 1'b0;
        w_finish      = 1'b0;
        should_update = 1'b0;
        busy          = 1'b1;
        scan_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (r_refresh_pending || (display != r_shadow)) begin
                    w_start = 1'b1;
                    w_next  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_full || (w_snap_byte != w_shadow_byte)) begin
                    w_load = 1'b1;
                    w_next = S_SEND;
                end else if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_SEND: begin
                should_update = 1'b1;
                if (tx_ack) begin
                    w_commit = 1'b1;
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                scan_done = 1'b1;
                w_finish  = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shadow          <= '0;
            r_snap            <= '0;
            r_idx             <= '0;
            r_full            <= 1'b0;
            r_refresh_pending <= 1'b0;
            r_chunk           <= '0;
            r_cnt             <= '0;
            r_chunks_sent     <= '0;
        end else begin
            // A refresh landing on the same edge a scan starts stays pending,
            // so no request is ever lost.
            r_refresh_pending <= (r_refresh_pending & ~w_start) | refresh;
            if (w_start) begin
                r_snap <= display;
                r_idx  <= '0;
                r_full <= r_refresh_pending;
                r_cnt  <= '0;
            end
            if (w_load) begin
                r_chunk <= {w_snap_byte, IXW'(r_idx)};
            end
            if (w_commit) begin
                for (int i = 0; i < N; i++) begin
                    if (r_idx == IW'(i)) r_shadow[i*8 +: 8] <= w_snap_byte;
                end
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_adv) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_finish) begin
                r_chunks_sent <= r_cnt;
            end
        end
    end

    assign tx_chunk_type  = INTERFACE_TX_CHUNK_TYPE;
    assign tx_chunk_bytes = r_chunk;
    assign chunks_sent    = r_chunks_sent;

endmodule
